// File: rtl/input_buffer.sv
// rtl/input_buffer.sv - Phoenix router per-port receive FIFO with header request/ack read FSM.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 16
`endif

module input_buffer #(
    parameter int TAM_FLIT   = `TAM_FLIT,
    parameter int TAM_BUFFER = `TAM_BUFFER
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    output logic [TAM_FLIT-1:0] data,
    input  logic                data_ack,
    output logic                sender
);
    localparam int PW = $clog2(TAM_BUFFER);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SEND_HDR, S_SEND_SIZE, S_PAYLOAD, S_END
    } state_t;

    logic [TAM_FLIT-1:0] fifo_q [TAM_BUFFER];
    logic [PW-1:0]       first_q, last_q;
    logic [PW:0]         count_q;
    logic [TAM_FLIT-1:0] rem_q, rem_d;
    state_t              state_q, state_d;
    logic                h_q, h_d;
    logic                sender_q, sender_d;
    logic                push, pop, not_empty, sending;

    assign not_empty = (count_q != '0);
    assign credit_o  = (count_q != (PW+1)'(TAM_BUFFER));
    assign sending   = (state_q == S_SEND_HDR) || (state_q == S_SEND_SIZE) ||
                       (state_q == S_PAYLOAD);
    assign data_av   = sending && not_empty;
    assign data      = fifo_q[first_q];
    assign push      = rx && credit_o;
    assign pop       = data_av && data_ack;
    assign h         = h_q;
    assign sender    = sender_q;

    // Storage is not reset; contents are only observed once count says they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[last_q] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_q <= '0;
            last_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                last_q <= last_q + 1'b1;
            end
            if (pop) begin
                first_q <= first_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            h_q      <= 1'b0;
            sender_q <= 1'b0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            sender_q <= sender_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        sender_d = sender_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE: begin
                h_d      = 1'b0;
                sender_d = 1'b0;
                if (not_empty) begin
                    state_d = S_REQ;
                    h_d     = 1'b1;
                end
            end
            S_REQ: begin
                h_d = 1'b1;
                if (ack_h) begin
                    h_d      = 1'b0;
                    sender_d = 1'b1;
                    state_d  = S_SEND_HDR;
                end
            end
            S_SEND_HDR: begin
                if (pop) begin
                    state_d = S_SEND_SIZE;
                end
            end
            S_SEND_SIZE: begin
                // A zero size field ends the packet right after the size flit.
                if (pop) begin
                    rem_d   = data;
                    state_d = (data != '0) ? S_PAYLOAD : S_END;
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == TAM_FLIT'(1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                sender_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                h_d      = 1'b0;
                sender_d = 1'b0;
            end
        endcase
    end
endmodule
